// File: rtl/delta_w_gen_pkg.sv
// Shared constants, vector type and FSM encoding for the delta_w generator.
package delta_w_gen_pkg;

   localparam int DATA_W  = 16;
   localparam int FRAC_W  = 8;
   localparam int VEC_LEN = 8;

   typedef logic [VEC_LEN-1:0][DATA_W-1:0] arr_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/delta_w_gen_scale.sv
// Combinational element datapath: y = sat(-((lr*x + half_lsb) >>> FRAC_W)).
module fx_scale_neg #(
   parameter int DATA_W = delta_w_gen_pkg::DATA_W,
   parameter int FRAC_W = delta_w_gen_pkg::FRAC_W
) (
   input  logic signed [DATA_W-1:0] lr,
   input  logic signed [DATA_W-1:0] x,
   output logic        [DATA_W-1:0] y
);

   // One guard bit above the full product keeps rounding and negation overflow-free.
   localparam int PW = 2*DATA_W + 1;
   localparam logic signed [PW-1:0] HALF    = PW'(1) << (FRAC_W-1);
   localparam logic signed [PW-1:0] SAT_MAX = (PW'(1) << (DATA_W-1)) - PW'(1);
   localparam logic signed [PW-1:0] SAT_MIN = -(PW'(1) << (DATA_W-1));

   logic signed [2*DATA_W-1:0] prod;
   logic signed [PW-1:0]       prod_ext;
   logic signed [PW-1:0]       rnd;
   logic signed [PW-1:0]       neg;

   assign prod     = lr * x;
   assign prod_ext = {prod[2*DATA_W-1], prod};
   assign rnd      = (prod_ext + HALF) >>> FRAC_W;
   assign neg      = -rnd;

   always_comb begin
      y = neg[DATA_W-1:0];
      if (neg > SAT_MAX) begin
         y = SAT_MAX[DATA_W-1:0];
      end else if (neg < SAT_MIN) begin
         y = SAT_MIN[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/delta_w_gen.sv
// Computes delta_w = -lr*grad element by element through one shared multiplier.
module delta_w_gen #(
   parameter int VEC_LEN = delta_w_gen_pkg::VEC_LEN,
   parameter int DATA_W  = delta_w_gen_pkg::DATA_W,
   parameter int FRAC_W  = delta_w_gen_pkg::FRAC_W
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   output logic                             in_ready,
   input  logic [VEC_LEN-1:0][DATA_W-1:0]   grad,
   input  logic [DATA_W-1:0]                lr,
   output logic [VEC_LEN-1:0][DATA_W-1:0]   delta_w,
   output logic                             out_valid,
   input  logic                             out_ready
);
   import delta_w_gen_pkg::*;

   localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_LEN-1);

   state_e                         state_reg, state_next;
   logic [IDX_W-1:0]               idx_reg, idx_next;
   logic [VEC_LEN-1:0][DATA_W-1:0] grad_reg;
   logic [DATA_W-1:0]              lr_reg;
   logic [DATA_W-1:0]              dw_reg [VEC_LEN];
   logic [VEC_LEN-1:0]             wr_en;
   logic [DATA_W-1:0]              elem_res;
   logic                           accept;

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               idx_next   = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            // Wrap on the last write so idx never leaves 0..VEC_LEN-1.
            if (idx_reg == IDX_LAST) begin
               idx_next   = '0;
               state_next = DONE;
            end else begin
               idx_next = idx_reg + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         grad_reg  <= '0;
         lr_reg    <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         if (accept) begin
            grad_reg <= grad;
            lr_reg   <= lr;
         end
      end
   end

   fx_scale_neg #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
   ) u_scale (
      .lr (lr_reg),
      .x  (grad_reg[idx_reg]),
      .y  (elem_res)
   );

   genvar gi;
   generate
      for (gi = 0; gi < VEC_LEN; gi++) begin : g_elem
         assign wr_en[gi]   = (state_reg == RUN) && (idx_reg == IDX_W'(gi));
         assign delta_w[gi] = dw_reg[gi];
      end
   endgenerate

   // Untouched elements keep their old value until their own RUN write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < VEC_LEN; i++) begin
            dw_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < VEC_LEN; i++) begin
            if (wr_en[i]) begin
               dw_reg[i] <= elem_res;
            end
         end
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);

endmodule

// File: tb/tb_delta_w_gen.sv
// Scoreboard bench for delta_w_gen: stimulus pushes expectations, monitor checks results.
module tb_delta_w_gen;
   import delta_w_gen_pkg::*;

   localparam int N  = VEC_LEN;
   localparam int AW = $bits(arr_t);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             out_ready = 1'b0;
   arr_t             grad = '0;
   logic [DATA_W-1:0] lr = '0;
   arr_t             delta_w;
   logic             in_ready;
   logic             out_valid;

   always #5 clk = ~clk;

   delta_w_gen dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_ready  (in_ready),
      .grad      (grad),
      .lr        (lr),
      .delta_w   (delta_w),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   typedef struct {
      arr_t  v;
      int    acc;
      string name;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   fails  = 0;
   int   cyc    = 0;
   bit   prev_valid = 1'b0;
   arr_t last_out = '0;

   // Directed vectors (element 0 first) and hand-computed results.
   logic [15:0] t1_g [8] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100};
   logic [15:0] t1_e [8] = '{16'hFF80, 16'hFF80, 16'hFF80, 16'hFF80, 16'hFF80, 16'hFF80, 16'hFF80, 16'hFF80};
   logic [15:0] t2_g [8] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
   logic [15:0] t2_e [8] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
   logic [15:0] t3_g [8] = '{16'h0080, 16'h007F, 16'h0100, 16'hFF00, 16'hFF80, 16'hFF7F, 16'h0180, 16'h7FFF};
   logic [15:0] t3_e [8] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 16'hFFFE, 16'hFF80};
   logic [15:0] t4_g [8] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050, 16'h0060, 16'h0070, 16'h0080};
   logic [15:0] t4_e [8] = '{16'hFFF0, 16'hFFE0, 16'hFFD0, 16'hFFC0, 16'hFFB0, 16'hFFA0, 16'hFF90, 16'hFF80};

   function automatic arr_t pk(input logic [15:0] a [8]);
      arr_t r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         r[i] = a[i];
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: one scoreboard pop per rising edge of out_valid.
   always @(negedge clk) begin
      exp_t e;
      if (out_valid && !prev_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_valid: out_valid rose with no pending transaction");
         end else begin
            e = sb_q.pop_front();
            chk({e.name, "_latency"}, AW'(cyc - e.acc), AW'(N));
            for (int i = 0; i < N; i++) begin
               chk($sformatf("%s_dw[%0d]", e.name, i), AW'(delta_w[i]), AW'(e.v[i]));
            end
            $display("txn %s: result latency %0d cycles, delta_w=%h", e.name, cyc - e.acc, delta_w);
         end
      end
      prev_valid = out_valid;
   end

   task automatic wait_valid(input string name);
      for (int k = 0; k < 40 && !out_valid; k++) begin
         @(negedge clk);
      end
      if (!out_valid) begin
         checks++;
         fails++;
         $display("FAIL %s_timeout: out_valid=%b, expected 1 within 40 cycles", name, out_valid);
      end
   endtask

   task automatic run_txn(input string name, input logic [15:0] l, input arr_t g, input arr_t e,
                          input bit scramble);
      @(negedge clk);
      lr    = l;
      grad  = g;
      start = 1'b1;
      chk({name, "_in_ready"}, AW'(in_ready), AW'(1));
      sb_q.push_back('{v: e, acc: cyc + 1, name: name});
      @(negedge clk);
      start = 1'b0;
      chk({name, "_hold_prev"}, AW'(delta_w), AW'(last_out));
      for (int k = 0; k < 40 && !out_valid; k++) begin
         if (scramble) begin
            lr = DATA_W'($urandom_range(0, 65535));
            for (int i = 0; i < N; i++) begin
               grad[i] = DATA_W'($urandom_range(0, 65535));
            end
         end
         @(negedge clk);
      end
      wait_valid(name);
      last_out  = delta_w;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({name, "_idle_ready"}, AW'(in_ready), AW'(1));
      chk({name, "_idle_valid"}, AW'(out_valid), AW'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", AW'(in_ready), AW'(1));
      chk("rst_out_valid", AW'(out_valid), AW'(0));
      chk("rst_delta_w", AW'(delta_w), AW'(0));
      rst_n = 1'b1;

      // T1: lr=0.5, grad=1.0; start held high through RUN and a stalled DONE
      @(negedge clk);
      lr    = 16'h0080;
      grad  = pk(t1_g);
      start = 1'b1;
      chk("t1_in_ready", AW'(in_ready), AW'(1));
      sb_q.push_back('{v: pk(t1_e), acc: cyc + 1, name: "t1"});
      @(negedge clk);
      wait_valid("t1");
      last_out = delta_w;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("t1_stall%0d_valid", c), AW'(out_valid), AW'(1));
         chk($sformatf("t1_stall%0d_in_ready", c), AW'(in_ready), AW'(0));
         chk($sformatf("t1_stall%0d_dw", c), AW'(delta_w), AW'(last_out));
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("t1_release_ready", AW'(in_ready), AW'(1));
      chk("t1_release_valid", AW'(out_valid), AW'(0));
      start     = 1'b0;
      out_ready = 1'b0;

      // T2: saturation in both directions
      run_txn("t2", 16'h7FFF, pk(t2_g), pk(t2_e), 1'b0);
      // T3: round-half-up then negate, small values
      run_txn("t3", 16'h0001, pk(t3_g), pk(t3_e), 1'b0);

      // Reset in the middle of RUN at idx=3
      @(negedge clk);
      lr    = 16'h0100;
      grad  = pk(t4_g);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_delta_w", AW'(delta_w), AW'(0));
      chk("abort_in_ready", AW'(in_ready), AW'(1));
      chk("abort_out_valid", AW'(out_valid), AW'(0));
      $display("txn abort: reset asserted during RUN");
      @(negedge clk);
      rst_n    = 1'b1;
      last_out = '0;

      // T4: inputs scrambled every cycle after accept
      run_txn("t4", 16'h0100, pk(t4_g), pk(t4_e), 1'b1);

      repeat (3) @(negedge clk);
      chk("sb_empty", AW'(sb_q.size()), AW'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
